// File: rtl/ula_multiciclo.sv
// Registered ALU: logic/arith/shift ops finish in 1 clock; MUL/DIV/REM iterate for WIDTH clocks.
// A start is accepted only while busy=0; res/flags change only at the edge that raises done.
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             neg,
  output logic             zero,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0]   WLIM = (WIDTH+1)'(WIDTH);
  localparam logic [SHW-1:0]   LAST = SHW'(WIDTH-1);
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_SHL = 4'b0100, OP_SHR = 4'b0101,
                         OP_XOR = 4'b0110, OP_NOT = 4'b0111, OP_XNR = 4'b1000,
                         OP_MUL = 4'b1001, OP_DIV = 4'b1010, OP_REM = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, rem_q, res_q;
  logic             is_rem_q, dz_q, busy_q, done_q, div_zero_q;

  logic             shamt_ok;
  logic [WIDTH-1:0] alu_d, mul_acc_d, quo_d, rem_d, div_res_d;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             ge;

  assign shamt_ok = ({1'b0, Y} < WLIM);

  always_comb begin
    alu_d = '0;
    case (sel)
      OP_ADD: alu_d = X + Y;
      OP_SUB: alu_d = X - Y;
      OP_AND: alu_d = X & Y;
      OP_OR:  alu_d = X | Y;
      OP_SHL: alu_d = shamt_ok ? (X << Y[SHW-1:0]) : '0;
      OP_SHR: alu_d = shamt_ok ? (X >> Y[SHW-1:0]) : '0;
      OP_XOR: alu_d = X ^ Y;
      OP_NOT: alu_d = ~X;
      OP_XNR: alu_d = ~(X ^ Y);
      default: alu_d = '0;
    endcase
  end

  // MUL: a_q = shifted multiplicand, b_q = multiplier consumed LSB first.
  assign mul_acc_d = acc_q + (b_q[0] ? a_q : '0);

  // DIV: a_q holds the dividend shifting out MSB first while quotient bits shift in.
  assign rem_sh  = {rem_q, a_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign ge      = ~rem_sub[WIDTH];
  assign quo_d   = {a_q[WIDTH-2:0], ge};
  assign rem_d   = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_res_d = dz_q ? (is_rem_q ? a_q : '1) : (is_rem_q ? rem_d : quo_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      is_rem_q   <= 1'b0;
      dz_q       <= 1'b0;
      res_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            a_q   <= X;
            b_q   <= Y;
            acc_q <= '0;
            rem_q <= '0;
            if (sel == OP_MUL) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
            end else if (sel == OP_DIV || sel == OP_REM) begin
              state_q  <= S_DIV;
              busy_q   <= 1'b1;
              is_rem_q <= (sel == OP_REM);
              dz_q     <= (Y == '0);
            end else begin
              res_q      <= alu_d;
              done_q     <= 1'b1;
              div_zero_q <= 1'b0;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          a_q   <= {a_q[WIDTH-2:0], 1'b0};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            res_q      <= mul_acc_d;
            div_zero_q <= 1'b0;
          end
        end
        S_DIV: begin
          // Divide by zero keeps a_q = X so REM can return it; only the counter runs.
          if (!dz_q) begin
            a_q   <= quo_d;
            rem_q <= rem_d;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            res_q      <= div_res_d;
            div_zero_q <= dz_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res      = res_q;
  assign neg      = res_q[WIDTH-1];
  assign zero     = (res_q == '0);
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench: a 32-bit and an 8-bit instance, expected results queued at issue time
// and popped by per-instance monitors whenever done is seen.
module tb_ula_multiciclo;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, SHL = 4'h4,
                         SHR = 4'h5, XOR_ = 4'h6, NOT_ = 4'h7, XNR = 4'h8, MUL = 4'h9,
                         DIV = 4'hA, REM = 4'hB;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q8[$];

  logic        start32, busy32, done32, neg32, zero32, dz32;
  logic [3:0]  sel32;
  logic [31:0] x32, y32, res32;
  logic        start8, busy8, done8, neg8, zero8, dz8;
  logic [3:0]  sel8;
  logic [7:0]  x8, y8, res8;

  ula_multiciclo #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sel(sel32), .X(x32), .Y(y32),
    .busy(busy32), .done(done32), .res(res32), .neg(neg32), .zero(zero32), .div_zero(dz32)
  );

  ula_multiciclo #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sel(sel8), .X(x8), .Y(y8),
    .busy(busy8), .done(done8), .res(res8), .neg(neg8), .zero(zero8), .div_zero(dz8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && done32 === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_done32: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q32.pop_front();
        check("res32", {32'h0, res32}, {32'h0, e.res});
        check("neg32", {63'h0, neg32}, {63'h0, e.res[31]});
        check("zero32", {63'h0, zero32}, {63'h0, (e.res == 32'h0)});
        check("div_zero32", {63'h0, dz32}, {63'h0, e.dz});
        check("done_cycle32", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_done8: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("res8", {56'h0, res8}, {56'h0, e.res[7:0]});
        check("neg8", {63'h0, neg8}, {63'h0, e.res[7]});
        check("zero8", {63'h0, zero8}, {63'h0, (e.res[7:0] == 8'h0)});
        check("div_zero8", {63'h0, dz8}, {63'h0, e.dz});
        check("done_cycle8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; start is held for exactly one rising edge.
  task automatic issue(input bit w8, input logic [3:0] s, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input logic ez);
    exp_t e;
    bit   multi;
    multi = (s == MUL) || (s == DIV) || (s == REM);
    e.res = er;
    e.dz  = ez;
    e.cyc = cyc + 1 + (multi ? (w8 ? 8 : 32) : 0);
    if (w8) begin
      start8 = 1'b1; sel8 = s; x8 = x[7:0]; y8 = y[7:0];
      q8.push_back(e);
    end else begin
      start32 = 1'b1; sel32 = s; x32 = x; y32 = y;
      q32.push_back(e);
    end
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic drain(input bit w8);
    int left;
    left = w8 ? q8.size() : q32.size();
    for (int i = 0; i < 200 && left != 0; i++) begin
      @(negedge clk);
      left = w8 ? q8.size() : q32.size();
    end
    if (left != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", left);
    end
  endtask

  task automatic reset_check();
    check("rst_res32", {32'h0, res32}, 64'h0);
    check("rst_zero32", {63'h0, zero32}, 64'h1);
    check("rst_neg32", {63'h0, neg32}, 64'h0);
    check("rst_busy32", {63'h0, busy32}, 64'h0);
    check("rst_done32", {63'h0, done32}, 64'h0);
    check("rst_dz32", {63'h0, dz32}, 64'h0);
    check("rst_res8", {56'h0, res8}, 64'h0);
    check("rst_zero8", {63'h0, zero8}, 64'h1);
    check("rst_busy8", {63'h0, busy8}, 64'h0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit busy_ok;
    rst = 1'b1;
    start32 = 1'b0; sel32 = 4'h0; x32 = '0; y32 = '0;
    start8  = 1'b0; sel8  = 4'h0; x8  = '0; y8  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_check();

    // Single-cycle ops, back to back
    issue(0, ADD,  32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0);
    issue(0, SUB,  32'h3,        32'h5,        32'hFFFFFFFE, 1'b0);
    issue(0, AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    issue(0, OR_,  32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0);
    issue(0, XOR_, 32'h5,        32'h3,        32'h00000006, 1'b0);
    issue(0, XNR,  32'h0F0F0F0F, 32'h00FF00FF, 32'hF00FF00F, 1'b0);
    issue(0, NOT_, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0);
    issue(0, SHL,  32'h1,        32'd31,       32'h80000000, 1'b0);
    issue(0, SHL,  32'h1,        32'd32,       32'h00000000, 1'b0);
    issue(0, SHR,  32'h80000000, 32'd4,        32'h08000000, 1'b0);
    issue(0, SHR,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    issue(0, 4'hC, 32'h5,        32'h6,        32'h00000000, 1'b0);
    drain(0);

    // MUL with busy monitoring and ignored start pulses
    issue(0, MUL, 32'h12345678, 32'h9, 32'hA3D70A38, 1'b0);
    busy_ok = 1'b1;
    for (int i = 0; i < 31; i++) begin
      if (busy32 !== 1'b1) busy_ok = 1'b0;
      start32 = i[0]; sel32 = ADD; x32 = 32'hDEAD; y32 = 32'hBEEF;
      @(negedge clk);
    end
    start32 = 1'b0;
    check("mul_busy_throughout", {63'h0, busy_ok}, 64'h1);
    drain(0);

    // MUL then ADD accepted in the done cycle
    issue(0, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    repeat (32) @(negedge clk);
    issue(0, ADD, 32'h2, 32'h3, 32'h5, 1'b0);
    drain(0);

    issue(0, DIV, 32'd100, 32'd7, 32'd14, 1'b0);        drain(0);
    issue(0, REM, 32'd100, 32'd7, 32'd2, 1'b0);         drain(0);
    issue(0, DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);    drain(0);
    issue(0, REM, 32'd5, 32'd0, 32'd5, 1'b1);           drain(0);
    issue(0, ADD, 32'd1, 32'd1, 32'd2, 1'b0);           drain(0);
    issue(0, DIV, 32'hFFFFFFFF, 32'd10, 32'h19999999, 1'b0); drain(0);
    issue(0, REM, 32'hFFFFFFFF, 32'd10, 32'd5, 1'b0);   drain(0);

    // Reset in the middle of a MUL: no done may follow
    issue(0, MUL, 32'd3, 32'd4, 32'd12, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    q32.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_check();
    repeat (40) @(negedge clk);
    issue(0, ADD, 32'd1, 32'd1, 32'd2, 1'b0);
    drain(0);

    // WIDTH=8 instance: throughput then MUL latency
    issue(1, ADD,  32'h07, 32'h01, 32'h08, 1'b0);
    issue(1, AND_, 32'hF0, 32'h3C, 32'h30, 1'b0);
    issue(1, MUL,  32'h0F, 32'h11, 32'hFF, 1'b0);
    drain(1);
    issue(1, 4'hF, 32'h12, 32'h34, 32'h00, 1'b0);
    issue(1, SHL,  32'h01, 32'd7,  32'h80, 1'b0);
    issue(1, SHL,  32'h01, 32'd8,  32'h00, 1'b0);
    drain(1);
    issue(1, DIV, 32'hFF, 32'h0F, 32'h11, 1'b0);  drain(1);
    issue(1, REM, 32'hFE, 32'h0F, 32'h0E, 1'b0);  drain(1);
    issue(1, DIV, 32'h08, 32'h00, 32'hFF, 1'b1);  drain(1);

    repeat (20) @(negedge clk);
    check("pending32_at_end", 64'(q32.size()), 64'h0);
    check("pending8_at_end", 64'(q8.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
